// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a blocking
// single-outstanding fill and saturating hit/miss counters.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                       state_q, state_d;
  logic [SETS-1:0]              valid_q;
  logic [SETS-1:0][TAG_W-1:0]   tag_q;
  logic [SETS-1:0][31:0]        data_q;
  logic [31:0]                  miss_addr_q, miss_addr_d;
  logic [31:0]                  hit_count_q, miss_count_q;

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             tag_match, miss_accept, fill_en;
  logic             unused_addr_lsb;

  // byte-offset bits never carry information for word fetches
  assign unused_addr_lsb = ^imemaddr[1:0];

  assign idx       = imemaddr[IDX_W+1:2];
  assign tag       = imemaddr[31:IDX_W+2];
  assign miss_idx  = miss_addr_q[IDX_W+1:2];
  assign miss_tag  = miss_addr_q[31:IDX_W+2];
  assign tag_match = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    miss_accept = 1'b0;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        imemload = data_q[idx];
        ihit     = imemREN && tag_match;
        if (imemREN && !tag_match) begin
          miss_accept = 1'b1;
          miss_addr_d = imemaddr;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // fill is committed: datapath inputs are ignored until it lands
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (ihit && hit_count_q != '1)
        hit_count_q <= hit_count_q + 32'd1;
      if (miss_accept && miss_count_q != '1)
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q[miss_idx] <= 1'b1;
      tag_q[miss_idx]   <= miss_tag;
      data_q[miss_idx]  <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed cycle table for the scripted corner cases, then
// random traffic checked against an address-level reference model.
module tb_icache;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;

  icache #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, ren;
    logic [31:0] addr;
    logic        w;
    logic [31:0] ld;
    logic        chk;
    logic        ih;
    logic [31:0] el;
    logic        er;
    logic [31:0] ea, hc, mc;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  // reference model: cache contents keyed by word address per frame
  bit          mv [SETS];
  logic [31:0] mwa[SETS];
  logic [31:0] md [SETS];
  bit          busy;
  logic [31:0] pend;
  longint      mhc, mmc;

  function automatic void add(logic rst, logic ren, logic [31:0] addr, logic w,
                              logic [31:0] ld, logic chk, logic ih, logic [31:0] el,
                              logic er, logic [31:0] ea, logic [31:0] hc, logic [31:0] mc);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr; v.w = w; v.ld = ld; v.chk = chk;
    v.ih = ih; v.el = el; v.er = er; v.ea = ea; v.hc = hc; v.mc = mc;
    tbl.push_back(v);
  endfunction

  task automatic cmp(string nm, int cyc, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int fidx(logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic bit m_hit();
    int i;
    i = fidx(imemaddr);
    return !busy && imemREN && mv[i] && (mwa[i] == (imemaddr >> 2));
  endfunction

  task automatic model_step();
    bit h;
    int i;
    h = m_hit();
    if (RST) begin
      for (int k = 0; k < SETS; k++) begin mv[k] = 0; md[k] = '0; mwa[k] = '0; end
      busy = 0; mhc = 0; mmc = 0;
    end else begin
      if (h && mhc < 64'hFFFFFFFF) mhc++;
      if (busy) begin
        if (!iwait) begin
          i = fidx(pend);
          mv[i] = 1; mwa[i] = pend >> 2; md[i] = iload; busy = 0;
        end
      end else if (imemREN && !h) begin
        busy = 1; pend = imemaddr;
        if (mmc < 64'hFFFFFFFF) mmc++;
      end
    end
  endtask

  task automatic drive(logic rst, logic ren, logic [31:0] addr, logic w, logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = w; iload = ld;
  endtask

  initial begin
    // rst ren addr w ld | chk ihit imemload iREN iaddr hit_cnt miss_cnt
    add(1,1,32'h00,1,0,           0,0,0,0,0,0,0);
    add(1,1,32'h00,1,0,           1,0,0,0,0,0,0);
    add(0,1,32'h00,1,0,           1,0,0,0,0,0,0);
    add(0,0,32'h00,0,32'h11111111,1,0,0,1,32'h00,0,1);
    // cold miss on 0x40 with three wait cycles
    add(0,1,32'h40,1,0,           1,0,32'h11111111,0,0,0,1);
    add(0,1,32'h40,1,32'hFFFFFFFF,1,0,0,1,32'h40,0,2);
    add(0,1,32'h40,1,32'hFFFFFFFF,1,0,0,1,32'h40,0,2);
    add(0,1,32'h40,1,32'hFFFFFFFF,1,0,0,1,32'h40,0,2);
    add(0,1,32'h40,0,32'h2001000A,1,0,0,1,32'h40,0,2);
    add(0,1,32'h40,1,0,           1,1,32'h2001000A,0,0,0,2);
    add(0,0,32'h40,1,0,           1,0,32'h2001000A,0,0,1,2);
    // conflict on index 1 between 0x04 and 0x44
    add(0,1,32'h04,1,0,           1,0,0,0,0,1,2);
    add(0,1,32'h04,0,32'hAAAA0000,1,0,0,1,32'h04,1,3);
    add(0,1,32'h44,1,0,           1,0,32'hAAAA0000,0,0,1,3);
    add(0,1,32'h44,0,32'hBBBB0000,1,0,0,1,32'h44,1,4);
    add(0,1,32'h04,1,0,           1,0,32'hBBBB0000,0,0,1,4);
    add(0,1,32'h44,1,0,           1,0,0,1,32'h04,1,5);
    add(0,1,32'h44,0,32'hAAAA0000,1,0,0,1,32'h04,1,5);
    add(0,1,32'h44,1,0,           1,0,32'hAAAA0000,0,0,1,5);
    add(0,1,32'h44,0,32'hBBBB0000,1,0,0,1,32'h44,1,6);
    add(0,0,32'h44,1,0,           1,0,32'hBBBB0000,0,0,1,6);
    // address change and request drop mid-fill
    add(0,1,32'h80,1,0,           1,0,32'h2001000A,0,0,1,6);
    add(0,1,32'h100,1,0,          1,0,0,1,32'h80,1,7);
    add(0,0,32'h100,1,0,          1,0,0,1,32'h80,1,7);
    add(0,1,32'h100,0,32'h80808080,1,0,0,1,32'h80,1,7);
    add(0,1,32'h100,1,0,          1,0,32'h80808080,0,0,1,7);
    add(0,1,32'h100,1,0,          1,0,0,1,32'h100,1,8);
    add(0,0,32'h100,0,32'h01000100,1,0,0,1,32'h100,1,8);
    add(0,1,32'h100,1,0,          1,1,32'h01000100,0,0,1,8);
    // reset collides with fill completion
    add(0,1,32'h0C,1,0,           1,0,0,0,0,2,8);
    add(1,1,32'h0C,0,32'hDEADBEEF,1,0,0,1,32'h0C,2,9);
    add(0,1,32'h0C,1,0,           1,0,0,0,0,0,0);
    add(0,1,32'h0C,0,32'h33333333,1,0,0,1,32'h0C,0,1);
    // preload 0x00/0x04/0x08 with zero wait, then back-to-back hits
    add(0,1,32'h00,1,0,           1,0,0,0,0,0,1);
    add(0,1,32'h00,0,32'h000000A0,1,0,0,1,32'h00,0,2);
    add(0,1,32'h04,1,0,           1,0,0,0,0,0,2);
    add(0,1,32'h04,0,32'h000000A4,1,0,0,1,32'h04,0,3);
    add(0,1,32'h08,1,0,           1,0,0,0,0,0,3);
    add(0,1,32'h08,0,32'h000000A8,1,0,0,1,32'h08,0,4);
    add(0,1,32'h00,1,0,           1,1,32'h000000A0,0,0,0,4);
    add(0,1,32'h04,1,0,           1,1,32'h000000A4,0,0,1,4);
    add(0,1,32'h08,1,0,           1,1,32'h000000A8,0,0,2,4);
    add(0,0,32'h08,1,0,           1,0,32'h000000A8,0,0,3,4);
    add(0,1,32'h0C,1,0,           1,1,32'h33333333,0,0,3,4);
    add(0,0,32'h00,1,0,           1,0,32'h000000A0,0,0,4,4);

    busy = 0; pend = '0; mhc = 0; mmc = 0;
    for (int k = 0; k < SETS; k++) begin mv[k] = 0; md[k] = '0; mwa[k] = '0; end
    drive(1, 0, '0, 1, '0);
    #1;

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].ren, tbl[n].addr, tbl[n].w, tbl[n].ld);
      @(negedge CLK);
      if (tbl[n].chk) begin
        cmp("ihit",       n, {31'd0, ihit}, {31'd0, tbl[n].ih});
        cmp("imemload",   n, imemload,      tbl[n].el);
        cmp("iREN",       n, {31'd0, iREN}, {31'd0, tbl[n].er});
        cmp("iaddr",      n, iaddr,         tbl[n].ea);
        cmp("hit_count",  n, hit_count,     tbl[n].hc);
        cmp("miss_count", n, miss_count,    tbl[n].mc);
      end
      model_step();
      @(posedge CLK); #1;
    end

    for (int c = 0; c < 4000; c++) begin
      logic [31:0] a;
      bit          eh;
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS-1) << 2);
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, a,
            $urandom_range(0, 1), $urandom);
      @(negedge CLK);
      eh = m_hit();
      cmp("rnd_ihit",     c, {31'd0, ihit}, {31'd0, eh});
      cmp("rnd_imemload", c, imemload, busy ? 32'd0 : md[fidx(imemaddr)]);
      cmp("rnd_iREN",     c, {31'd0, iREN}, {31'd0, busy});
      cmp("rnd_iaddr",    c, iaddr, busy ? pend : 32'd0);
      cmp("rnd_hit_count",  c, hit_count,  mhc[31:0]);
      cmp("rnd_miss_count", c, miss_count, mmc[31:0]);
      model_step();
      @(posedge CLK); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
